// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R   = 3'd0,
    CLS_ALU_I   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } iclass_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of the latched opcode/funct7 fields into
// instruction class and ALU/immediate controls.
module mc_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic       funct7b5_i,
  output iclass_t    iclass_o,
  output logic [2:0] aluctrl_o,
  output logic       alusrc_o,
  output logic [1:0] immsrc_o
);

  always_comb begin
    iclass_o  = CLS_ILLEGAL;
    aluctrl_o = ALU_ADD;
    alusrc_o  = 1'b0;
    immsrc_o  = IMM_I;
    case (opcode_i)
      OP_RTYPE: begin
        iclass_o  = CLS_ALU_R;
        aluctrl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
      end
      OP_ITYPE: begin
        iclass_o = CLS_ALU_I;
        alusrc_o = 1'b1;
      end
      OP_LOAD: begin
        iclass_o = CLS_LOAD;
        alusrc_o = 1'b1;
      end
      OP_STORE: begin
        iclass_o = CLS_STORE;
        alusrc_o = 1'b1;
        immsrc_o = IMM_S;
      end
      OP_BRANCH: begin
        iclass_o  = CLS_BRANCH;
        aluctrl_o = ALU_SUB;
        immsrc_o  = IMM_B;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control FSM (fetch/decode/exec/mem/wb/halt).
// Optional cycle/retired counters are built when MC_PERF_COUNTERS_EN is defined.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  eq,
  input  logic                  mem_ready,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  regwrite,
  output logic                  alusrc,
  output logic                  pcsrc,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  result_src,
  output logic                  halted,
  output logic [2:0]            aluctrl,
  output logic [1:0]            immsrc,
  output logic [2:0]            state_o
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [COUNT_WIDTH-1:0] cycle_cnt,
  output logic [COUNT_WIDTH-1:0] retired_cnt
`endif
);

  if (DATA_WIDTH < 32 || COUNT_WIDTH < 1) begin : g_cfg_check
    $error("mc_sequencer: DATA_WIDTH must be >= 32 and COUNT_WIDTH >= 1");
  end

  state_t     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic [2:0] funct3_q, funct3_d;
  logic       funct7b5_q, funct7b5_d;

  iclass_t    dec_iclass;
  logic [2:0] dec_aluctrl;
  logic       dec_alusrc;
  logic [1:0] dec_immsrc;

  mc_decode u_decode (
    .opcode_i   (opcode_q),
    .funct7b5_i (funct7b5_q),
    .iclass_o   (dec_iclass),
    .aluctrl_o  (dec_aluctrl),
    .alusrc_o   (dec_alusrc),
    .immsrc_o   (dec_immsrc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    regwrite   = 1'b0;
    alusrc     = 1'b0;
    pcsrc      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    result_src = 1'b0;
    halted     = 1'b0;
    aluctrl    = ALU_ADD;
    immsrc     = IMM_I;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        ir_we      = 1'b1;
        opcode_d   = instr[6:0];
        funct3_d   = instr[14:12];
        funct7b5_d = instr[30];
        state_d    = ST_DECODE;
      end
      ST_DECODE: state_d = (dec_iclass == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        aluctrl = dec_aluctrl;
        alusrc  = dec_alusrc;
        immsrc  = dec_immsrc;
        case (dec_iclass)
          CLS_BRANCH: begin
            // funct3[0] distinguishes bne from beq, inverting the take condition
            pc_we   = 1'b1;
            pcsrc   = eq ^ funct3_q[0];
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec_iclass == CLS_STORE);
        if (mem_ready) begin
          if (dec_iclass == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        regwrite   = 1'b1;
        pc_we      = 1'b1;
        result_src = (dec_iclass == CLS_LOAD);
        state_d    = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o = state_q;

  logic unused_bits;
  assign unused_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7], funct3_q[2:1]};

`ifdef MC_PERF_COUNTERS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNT_WIDTH-1:0] cycle_cnt_q, retired_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
      if (pc_we)              retired_cnt_q <= retired_cnt_q + CNT_ONE;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-cycle expected output words are
// queued as stimulus is driven and compared at the falling edge.
module tb_mc_sequencer;

  localparam logic [2:0] T_IDLE = 3'd0, T_FETCH = 3'd1, T_DEC = 3'd2, T_EXEC = 3'd3,
                         T_MEM = 3'd4, T_WB = 3'd5, T_HALT = 3'd6;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001;
  localparam logic [1:0] IMI = 2'b00, IMS = 2'b01, IMB = 2'b10;
  // strobe word: {ir_we, pc_we, regwrite, alusrc, pcsrc, mem_req, mem_we, result_src, halted}
  localparam logic [8:0] S_IR = 9'b100000000, S_PC = 9'b010000000, S_RW = 9'b001000000,
                         S_AS = 9'b000100000, S_PS = 9'b000010000, S_MR = 9'b000001000,
                         S_MW = 9'b000000100, S_RS = 9'b000000010, S_H  = 9'b000000001;
  localparam logic [31:0] I_ADDI = 32'h00500093, I_ADD = 32'h00208033, I_SUB = 32'h40208033,
                          I_BNE  = 32'h00209463, I_BEQ = 32'h00208463, I_LW  = 32'h0000A103,
                          I_SW   = 32'h0020A023, I_ILL = 32'h0000007F;

  logic        clk;
  logic        rst, eq, mem_ready;
  logic [31:0] instr;
  logic        ir_we, pc_we, regwrite, alusrc, pcsrc, mem_req, mem_we, result_src, halted;
  logic [2:0]  aluctrl, state_o;
  logic [1:0]  immsrc;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, retired_cnt;
  int unsigned m_cyc = 0, m_ret = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_idx  = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_vec;

  mc_sequencer #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .eq         (eq),
    .mem_ready  (mem_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .regwrite   (regwrite),
    .alusrc     (alusrc),
    .pcsrc      (pcsrc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .result_src (result_src),
    .halted     (halted),
    .aluctrl    (aluctrl),
    .immsrc     (immsrc),
    .state_o    (state_o)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
`endif
  );

  assign obs_vec = {state_o, aluctrl, immsrc, ir_we, pc_we, regwrite, alusrc, pcsrc,
                    mem_req, mem_we, result_src, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ev(input logic [2:0] st, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic [8:0] strb);
    return {st, alu, imm, strb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [31:0] ins,
                      input logic e, input logic mr, input logic [16:0] exp);
    logic [16:0] want;
    rst       = r;
    instr     = ins;
    eq        = e;
    mem_ready = mr;
    exp_q.push_back(exp);
    @(negedge clk);
    want = exp_q.pop_front();
    chk($sformatf("%s@%0d", tag, cyc_idx), {15'd0, obs_vec}, {15'd0, want});
`ifdef MC_PERF_COUNTERS_EN
    chk($sformatf("cycle_cnt@%0d", cyc_idx), cycle_cnt, m_cyc);
    chk($sformatf("retired_cnt@%0d", cyc_idx), retired_cnt, m_ret);
    if (r) begin
      m_cyc = 0;
      m_ret = 0;
    end else begin
      if (want[16:14] != T_HALT) m_cyc++;
      if (want[7]) m_ret++;
    end
`endif
    cyc_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] br_ins [4];
    logic        br_eq  [4];
    logic        br_ps  [4];
    br_ins = '{I_BNE, I_BNE, I_BEQ, I_BEQ};
    br_eq  = '{1'b0, 1'b1, 1'b1, 1'b0};
    br_ps  = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; instr = '0; eq = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held, then addi
    step("rst0",      1'b1, I_ADDI, 1'b0, 1'b0, ev(T_IDLE, ADD, IMI, 9'd0));
    step("rst1",      1'b1, I_ADDI, 1'b0, 1'b0, ev(T_IDLE, ADD, IMI, 9'd0));
    step("addi_idle", 1'b0, I_ADDI, 1'b0, 1'b0, ev(T_IDLE, ADD, IMI, 9'd0));
    step("addi_f",    1'b0, I_ADDI, 1'b0, 1'b0, ev(T_FETCH, ADD, IMI, S_IR));
    step("addi_d",    1'b0, I_ADDI, 1'b0, 1'b0, ev(T_DEC, ADD, IMI, 9'd0));
    step("addi_e",    1'b0, I_ADDI, 1'b0, 1'b0, ev(T_EXEC, ADD, IMI, S_AS));
    step("addi_wb",   1'b0, I_ADDI, 1'b0, 1'b0, ev(T_WB, ADD, IMI, S_RW | S_PC));

    // R-type add then sub
    for (int i = 0; i < 2; i++) begin
      logic [31:0] ins;
      ins = (i == 1) ? I_SUB : I_ADD;
      step("r_f",  1'b0, ins, 1'b1, 1'b0, ev(T_FETCH, ADD, IMI, S_IR));
      step("r_d",  1'b0, ins, 1'b1, 1'b0, ev(T_DEC, ADD, IMI, 9'd0));
      step("r_e",  1'b0, ins, 1'b1, 1'b0, ev(T_EXEC, (i == 1) ? SUB : ADD, IMI, 9'd0));
      step("r_wb", 1'b0, ins, 1'b1, 1'b0, ev(T_WB, ADD, IMI, S_RW | S_PC));
    end

    // branches: bne/beq with both eq values, no WB visit
    for (int i = 0; i < 4; i++) begin
      step("br_f", 1'b0, br_ins[i], br_eq[i], 1'b0, ev(T_FETCH, ADD, IMI, S_IR));
      step("br_d", 1'b0, br_ins[i], br_eq[i], 1'b0, ev(T_DEC, ADD, IMI, 9'd0));
      step("br_e", 1'b0, br_ins[i], br_eq[i], 1'b0,
           ev(T_EXEC, SUB, IMB, S_PC | (br_ps[i] ? S_PS : 9'd0)));
    end

    // lw with stray mem_ready before MEM and 3 wait cycles
    step("lw_f", 1'b0, I_LW, 1'b0, 1'b1, ev(T_FETCH, ADD, IMI, S_IR));
    step("lw_d", 1'b0, I_LW, 1'b0, 1'b1, ev(T_DEC, ADD, IMI, 9'd0));
    step("lw_e", 1'b0, I_LW, 1'b0, 1'b1, ev(T_EXEC, ADD, IMI, S_AS));
    for (int i = 0; i < 3; i++)
      step("lw_mwait", 1'b0, I_LW, 1'b0, 1'b0, ev(T_MEM, ADD, IMI, S_MR));
    step("lw_mlast", 1'b0, I_LW, 1'b0, 1'b1, ev(T_MEM, ADD, IMI, S_MR));
    step("lw_wb",    1'b0, I_LW, 1'b0, 1'b0, ev(T_WB, ADD, IMI, S_RW | S_PC | S_RS));

    // sw with zero and two wait cycles
    for (int n = 0; n < 3; n += 2) begin
      step("sw_f", 1'b0, I_SW, 1'b0, 1'b0, ev(T_FETCH, ADD, IMI, S_IR));
      step("sw_d", 1'b0, I_SW, 1'b0, 1'b0, ev(T_DEC, ADD, IMI, 9'd0));
      step("sw_e", 1'b0, I_SW, 1'b0, 1'b0, ev(T_EXEC, ADD, IMS, S_AS));
      for (int w = 0; w < n; w++)
        step("sw_mwait", 1'b0, I_SW, 1'b0, 1'b0, ev(T_MEM, ADD, IMI, S_MR | S_MW));
      step("sw_mlast", 1'b0, I_SW, 1'b0, 1'b1, ev(T_MEM, ADD, IMI, S_MR | S_MW | S_PC));
    end

    // reset in the second MEM wait cycle of a lw
    step("rm_f",  1'b0, I_LW, 1'b0, 1'b0, ev(T_FETCH, ADD, IMI, S_IR));
    step("rm_d",  1'b0, I_LW, 1'b0, 1'b0, ev(T_DEC, ADD, IMI, 9'd0));
    step("rm_e",  1'b0, I_LW, 1'b0, 1'b0, ev(T_EXEC, ADD, IMI, S_AS));
    step("rm_m1", 1'b0, I_LW, 1'b0, 1'b0, ev(T_MEM, ADD, IMI, S_MR));
    step("rm_m2", 1'b1, I_LW, 1'b0, 1'b0, ev(T_MEM, ADD, IMI, S_MR));
    step("rm_idle", 1'b0, I_ILL, 1'b0, 1'b1, ev(T_IDLE, ADD, IMI, 9'd0));

    // illegal opcode -> HALT, sticky until reset
    step("ill_f", 1'b0, I_ILL, 1'b0, 1'b0, ev(T_FETCH, ADD, IMI, S_IR));
    step("ill_d", 1'b0, I_ILL, 1'b0, 1'b0, ev(T_DEC, ADD, IMI, 9'd0));
    for (int i = 0; i < 20; i++)
      step("halt", 1'b0, I_ILL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ev(T_HALT, ADD, IMI, S_H));
    step("halt_rst", 1'b1, I_ADDI, 1'b0, 1'b0, ev(T_HALT, ADD, IMI, S_H));
    step("post_rst", 1'b0, I_ADDI, 1'b0, 1'b0, ev(T_IDLE, ADD, IMI, 9'd0));
    step("post_f",   1'b0, I_ADDI, 1'b0, 1'b0, ev(T_FETCH, ADD, IMI, S_IR));

    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
